csa_resolver: RTL

Sequential carry-propagate stage that consumes the redundant two-vector (sum/carry) output of the carry-save compression tree and resolves it into a single binary word plus carry-out. It sits at the tail of the Dadda multiplier datapath, after the last 4:2 compression level. It processes CHUNK bits per cycle, least significant chunk first, so the long carry chain never sits in a single cycle. Valid/ready handshakes are used on both sides.

---
 rtl/csa_resolver.sv | 123 ++++++++++++
 1 files changed

// File: rtl/csa_resolver.sv
// rtl/csa_resolver.sv - chunked carry-propagate resolver for the sum/carry vectors of the carry-save tree
// Resolves CHUNK bits per cycle, LS chunk first; valid/ready on both sides.
module csa_resolver #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int OW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cout_q;
    logic [KW-1:0]    k_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [OW-1:0]    off_d;
    logic [CHUNK-1:0] chunk_a_d;
    logic [CHUNK-1:0] chunk_b_d;
    logic [CHUNK:0]   chunk_sum_d;
    logic             accept_d;

    // The only carry path between chunks is carry_q, so the adder is CHUNK+1 bits wide.
    always_comb begin
        off_d       = OW'(int'(k_q) * CHUNK);
        chunk_a_d   = a_q[off_d +: CHUNK];
        chunk_b_d   = b_q[off_d +: CHUNK];
        chunk_sum_d = {1'b0, chunk_a_d} + {1'b0, chunk_b_d} + {{CHUNK{1'b0}}, carry_q};
    end

    // DONE hands the slot straight to a new operand pair once the result leaves.
    assign in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign accept_d = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            k_q         <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_d) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        k_q     <= '0;
                        carry_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    sum_q[off_d +: CHUNK] <= chunk_sum_d[CHUNK-1:0];
                    carry_q               <= chunk_sum_d[CHUNK];
                    k_q                   <= k_q + 1'b1;
                    if (k_q == K_LAST) begin
                        cout_q      <= chunk_sum_d[CHUNK];
                        k_q         <= '0;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (accept_d) begin
                            a_q     <= in_a;
                            b_q     <= in_b;
                            k_q     <= '0;
                            carry_q <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= S_RUN;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;

endmodule
